// File: rtl/clock_monitor.sv
// clock_monitor
//   Watches NCH asynchronous clocks from the clk domain. Each channel
//   synchronises its netclk, detects rising edges and declares the clock
//   lost after TIMEOUT clk cycles with no edge. A lost clock is declared
//   present again only after RECOVER consecutive edges, each arriving
//   within TIMEOUT of the previous one. Each loss sets a sticky flag that
//   software clears, and the OR of the sticky flags drives irq.
//
// Ports
//   clk          system clock (only clock domain)
//   reset_n      synchronous active-low reset
//   netclk       [NCH] monitored clocks, asynchronous to clk
//   lost_clear   [NCH] write-one-to-clear for lost_sticky
//   no_clock     [NCH] registered, 1 while the channel is lost
//   lost_sticky  [NCH] registered, set on each PRESENT->LOST transition
//   irq          OR of lost_sticky

// Per-channel monitor: synchroniser, edge detect, timeout counter and
// loss/recovery state machine.
module clock_monitor_ch #(
   parameter int TIMEOUT     = 2048,
   parameter int CW          = 12,
   parameter int RECOVER     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic netclk,
   input  logic lost_clear,
   output logic no_clock,
   output logic lost_sticky
);
   localparam int             RCW       = $clog2(RECOVER) + 1;
   localparam logic [CW-1:0]  CNT_MAX   = CW'(TIMEOUT - 1);
   localparam logic [RCW-1:0] RCNT_LAST = RCW'(RECOVER - 1);

   typedef enum logic [1:0] {PRESENT, LOST, RECOVERING} state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   edge_det;
   logic                   tmo;
   logic [CW-1:0]          cnt;
   logic [RCW-1:0]         rcnt;
   state_t                 state;

   assign edge_det = sync[SYNC_STAGES-1] & ~prev;
   assign tmo      = ~edge_det && (cnt == CNT_MAX);

   // Synchroniser, history flop and timeout counter. The counter
   // saturates so a stuck clock keeps tmo asserted instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync <= '0;
         prev <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], netclk};
         prev <= sync[SYNC_STAGES-1];
         if (edge_det)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   // Loss/recovery FSM. The sticky set is placed after the clear so a
   // loss in the same cycle as a software clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= PRESENT;
         rcnt        <= '0;
         no_clock    <= 1'b0;
         lost_sticky <= 1'b0;
      end else begin
         if (lost_clear)
            lost_sticky <= 1'b0;
         case (state)
            PRESENT: begin
               if (tmo) begin
                  state       <= LOST;
                  no_clock    <= 1'b1;
                  lost_sticky <= 1'b1;
               end
            end
            LOST: begin
               if (edge_det) begin
                  if (RECOVER == 1) begin
                     state    <= PRESENT;
                     no_clock <= 1'b0;
                  end else begin
                     state <= RECOVERING;
                     rcnt  <= RCW'(1);
                  end
               end
            end
            RECOVERING: begin
               if (edge_det) begin
                  if (rcnt == RCNT_LAST) begin
                     state    <= PRESENT;
                     no_clock <= 1'b0;
                     rcnt     <= '0;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end else if (tmo) begin
                  // Gap during recovery: start over, but this is not a new
                  // loss event, so the sticky flag is left alone.
                  state <= LOST;
                  rcnt  <= '0;
               end
            end
            default: begin
               state    <= PRESENT;
               rcnt     <= '0;
               no_clock <= 1'b0;
            end
         endcase
      end
   end
endmodule

module clock_monitor #(
   parameter int NCH         = 4,
   parameter int TIMEOUT     = 2048,
   parameter int CW          = 12,
   parameter int RECOVER     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [NCH-1:0] netclk,
   input  logic [NCH-1:0] lost_clear,
   output logic [NCH-1:0] no_clock,
   output logic [NCH-1:0] lost_sticky,
   output logic           irq
);
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clock_monitor_ch #(
         .TIMEOUT    (TIMEOUT),
         .CW         (CW),
         .RECOVER    (RECOVER),
         .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .netclk     (netclk[i]),
         .lost_clear (lost_clear[i]),
         .no_clock   (no_clock[i]),
         .lost_sticky(lost_sticky[i])
      );
   end

   // Pure OR of flops: irq tracks lost_sticky in the same cycle.
   assign irq = |lost_sticky;
endmodule

// File: tb/tb_clock_monitor.sv
module tb_clock_monitor;
   localparam int NCH = 2, TIMEOUT = 16, CW = 5, RECOVER = 4, SYNC = 2, HP = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [NCH-1:0] netclk, lost_clear, no_clock, lost_sticky;
   logic           irq;

   clock_monitor #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CW(CW), .RECOVER(RECOVER),
                   .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .netclk(netclk), .lost_clear(lost_clear),
      .no_clock(no_clock), .lost_sticky(lost_sticky), .irq(irq));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs after the clk edge numbered cyc
   typedef struct {
      int         cyc;
      logic [1:0] nc;
      logic [1:0] ls;
      logic       irq;
      bit         chk_cnt;
      logic [4:0] cnt;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0;

   // Stimulus-side state
   logic [1:0] run_ch = 2'b00;
   int         ph[2] = '{0, 2};
   int         last_rise[2] = '{0, 0};
   int         rise_cnt[2] = '{0, 0};
   bit         just_tog[2] = '{0, 0};
   logic [1:0] exp_nc = 2'b00, exp_ls = 2'b00;
   bit         exp_chk = 1'b0;
   string      phase = "init";

   // Monitor: pops expectations as their cycle comes up
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL %s stale expectation for cycle %0d seen at %0d", e.tag, e.cyc, cyc);
            end else if ({no_clock, lost_sticky, irq} !== {e.nc, e.ls, e.irq}) begin
               errors++;
               $display("FAIL %s cyc=%0d got nc=%b ls=%b irq=%b want nc=%b ls=%b irq=%b",
                        e.tag, cyc, no_clock, lost_sticky, irq, e.nc, e.ls, e.irq);
            end
            if (e.chk_cnt) begin
               checks++;
               if (dut.g_ch[1].u_ch.cnt !== e.cnt) begin
                  errors++;
                  $display("FAIL %s_cnt cyc=%0d got %0d want %0d", e.tag, cyc,
                           dut.g_ch[1].u_ch.cnt, e.cnt);
               end
            end
         end
      end
   end

   // One clk cycle: queue the expectation for the coming edge, then advance
   // the free-running netclk generators (half period HP).
   task automatic step();
      exp_t e;
      e.cyc = cyc + 1; e.nc = exp_nc; e.ls = exp_ls; e.irq = |exp_ls;
      e.chk_cnt = exp_chk; e.cnt = 5'd15; e.tag = phase;
      q.push_back(e);
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
         just_tog[c] = 1'b0;
         if (run_ch[c]) begin
            ph[c]++;
            if (ph[c] == HP) begin
               ph[c] = 0;
               netclk[c] = ~netclk[c];
               just_tog[c] = 1'b1;
               if (netclk[c]) begin
                  rise_cnt[c]++;
                  last_rise[c] = cyc + 1;   // edge that samples the rise
               end
            end
         end
      end
   endtask

   // Stop channel c at level lvl right after it toggles there; loss is
   // expected 18 edges after the last sampled rise.
   task automatic lose(input int c, input logic lvl, input bit race);
      int r;
      while (!(just_tog[c] && netclk[c] == lvl)) step();
      run_ch[c] = 1'b0;
      r = last_rise[c];
      while (cyc < r + 17) step();
      if (race) lost_clear[c] = 1'b1;
      exp_nc[c] = 1'b1;
      exp_ls[c] = 1'b1;
      step();
      lost_clear[c] = 1'b0;
   endtask

   // Resume channel c; no_clock falls two edges after the n-th rise is sampled.
   task automatic recover(input int c, input int n);
      int tgt, r;
      tgt = rise_cnt[c] + n;
      run_ch[c] = 1'b1;
      while (rise_cnt[c] < tgt) step();
      r = last_rise[c];
      while (cyc < r + 1) step();
      exp_nc[c] = 1'b0;
      step();
   endtask

   task automatic clear(input int c);
      lost_clear[c] = 1'b1;
      exp_ls[c] = 1'b0;
      step();
      lost_clear[c] = 1'b0;
   endtask

   initial begin
      int tgt, rr;
      reset_n = 1'b0; netclk = '0; lost_clear = '0;

      phase = "reset";
      repeat (3) step();
      reset_n = 1'b1;
      run_ch = 2'b11;
      phase = "steady";
      repeat (300) step();

      phase = "loss";
      lose(0, 1'b0, 1'b0);
      repeat (5) step();

      phase = "recover";
      recover(0, 4);
      repeat (10) step();
      phase = "clear";
      clear(0);
      repeat (5) step();

      phase = "interrupted";
      lose(0, 1'b0, 1'b0);
      clear(0);
      run_ch[0] = 1'b1;
      tgt = rise_cnt[0] + 2;
      while (rise_cnt[0] < tgt) step();
      while (!(just_tog[0] && !netclk[0])) step();
      run_ch[0] = 1'b0;
      repeat (20) step();
      recover(0, 4);
      repeat (5) step();

      phase = "stuck_high";
      lose(1, 1'b1, 1'b0);
      exp_chk = 1'b1;
      repeat (5000) step();
      exp_chk = 1'b0;

      phase = "race";
      recover(1, 4);
      clear(1);
      repeat (3) step();
      lose(1, 1'b0, 1'b1);
      repeat (5) step();

      phase = "mid_recover_reset";
      lose(0, 1'b0, 1'b0);
      run_ch[0] = 1'b1;
      tgt = rise_cnt[0] + 2;
      while (rise_cnt[0] < tgt) step();
      repeat (3) step();
      reset_n = 1'b0;
      netclk = 2'b11;
      run_ch = 2'b00;
      exp_nc = 2'b00;
      exp_ls = 2'b00;
      step();
      rr = cyc;
      reset_n = 1'b1;
      phase = "post_reset";
      while (cyc < rr + 18) step();
      exp_nc = 2'b11;
      exp_ls = 2'b11;
      step();
      repeat (3) step();

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clock_monitor.md
# clock_monitor

Multi-channel network clock activity monitor: the parametrised successor to the single-channel clock-loss detector. Each of `NCH` asynchronous input clocks is synchronised into the `clk` domain and edge-detected. A per-channel timeout declares the clock lost, and a recovery state machine requires `RECOVER` consecutive good edges before the clock is declared present again. Per-channel sticky loss flags with software clear feed a single interrupt line to the station controller.

## Interface
Parameters:
- `NCH`, 4: number of monitored clocks.
- `TIMEOUT`, 2048: `clk` cycles without a detected rising edge before a channel is declared lost.
- `CW`, 12: counter width; must satisfy 2^CW > TIMEOUT.
- `RECOVER`, 4: consecutive rising edges, each within `TIMEOUT` of the previous one, needed to clear `no_clock`. Must be ≥ 1.
- `SYNC_STAGES`, 2: synchroniser depth; must be ≥ 2.

Ports:
- `clk`  in  1: system clock; the only clock domain.
- `reset_n`  in  1: synchronous, active-low reset.
- `netclk`  in  NCH: monitored clocks, asynchronous to `clk`.
- `lost_clear`  in  NCH: per-channel write-one-to-clear for `lost_sticky`.
- `no_clock`  out  NCH: registered; 1 means the channel is currently lost.
- `lost_sticky`  out  NCH: registered; set on each loss event.
- `irq`  out  1: OR of `lost_sticky`, built from registers only.

## Operation
- Each channel is independent. All channels share the same parameters.
- Synchroniser: `netclk[i]` passes through `SYNC_STAGES` flops, followed by one history flop `prev`. All of these reset to 0.
- `edge` = sync_out & ~prev. This is one cycle wide per rising edge.
- Timeout counter `cnt`, width CW:
  - `edge` → `cnt` <= 0.
  - Otherwise `cnt` increments, saturating at TIMEOUT-1. It never wraps.
  - `tmo` = !edge && cnt == TIMEOUT-1.
- FSM states, per channel:
  - PRESENT: the reset state.
    - `tmo` → LOST; set `no_clock`; set `lost_sticky`.
  - LOST:
    - `edge` with RECOVER==1 → PRESENT; clear `no_clock`.
    - `edge` with RECOVER>1 → RECOVERING; `rcnt` <= 1.
  - RECOVERING:
    - `edge` with rcnt==RECOVER-1 → PRESENT; clear `no_clock`; `rcnt` <= 0.
    - `edge` otherwise → `rcnt`+1.
    - `tmo` → LOST; `rcnt` <= 0; `no_clock` stays 1; `lost_sticky` is not set again.
- `lost_sticky[i]`:
  - Set only on a PRESENT→LOST transition.
  - Cleared when `lost_clear[i]`=1.
  - If set and clear occur in the same cycle, set wins.
- `rcnt` width is clog2(RECOVER)+1.

## Timing
- Reset values while `reset_n` is low at a `clk` edge:
  - `no_clock`=0, `lost_sticky`=0, `irq`=0.
  - FSM=PRESENT, `cnt`=0, `rcnt`=0, all synchroniser and history flops 0.
- Reset mid-operation aborts any state, including LOST and RECOVERING, on the next `clk` edge.
- If `netclk` is high at reset release, one edge is detected `SYNC_STAGES` cycles later. This is legal and only clears `cnt`.
- Edge latency: a `netclk` rise sampled at `clk` edge r gives `edge`=1 during cycle r+SYNC_STAGES-1. `cnt` clears at edge r+SYNC_STAGES.
- Loss latency: with the last `cnt` clear at edge c and no further edge, `no_clock` rises at edge c+TIMEOUT.
  - This matches the legacy detector's 2048-cycle threshold at default parameters.
- Recovery latency: `no_clock` falls at the `clk` edge that consumes the RECOVER-th `edge`.
- `irq` follows `lost_sticky` with no added latency, because it is an OR of registered bits.
- Input constraint: each `netclk` high and low phase must be ≥ SYNC_STAGES+1 `clk` periods for every edge to be counted.
- A `netclk` stuck high or stuck low is treated identically: both are lost.

## Test plan
Bench configuration: NCH=2, TIMEOUT=16, CW=5, RECOVER=4, SYNC_STAGES=2.
1. Reset and steady clock: hold `reset_n`=0 for 3 cycles, then toggle `netclk[0]` every 4 cycles for 300 cycles → `no_clock`=0, `lost_sticky`=0 and `irq`=0 throughout.
2. Loss: stop `netclk[0]` low after its last rise at edge r → `no_clock[0]` and `lost_sticky[0]` go to 1 exactly at edge r+18. `irq`=1. Channel 1 is unaffected.
3. Recovery: resume toggling with a period of 8 → `no_clock[0]` stays 1 after edges 1–3 and falls on the edge consuming the 4th detected rise. `lost_sticky[0]` stays 1 until `lost_clear[0]` is pulsed, after which `irq`=0.
4. Interrupted recovery: 2 rises, then a gap of 20 cycles, then 4 rises → `no_clock` stays 1 through the gap with no new sticky set. It clears only after the 4 later rises.
5. Saturation and race: hold `netclk[1]` high for 5000 cycles → `no_clock[1]`=1 permanently and `cnt` is held at 15 with no wrap. Pulse `lost_clear[1]` in the same cycle as a new loss event → `lost_sticky[1]` remains 1.
6. Reset mid-recovery: assert `reset_n`=0 in RECOVERING → at the next edge all outputs are 0. A subsequent silence gives loss after TIMEOUT+SYNC_STAGES cycles.
